// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op encodings and op-decode helpers for the multiply/divide unit
package mul_div_unit_pkg;

   localparam logic [1:0] MDU_MULT  = 2'd0;
   localparam logic [1:0] MDU_MULTU = 2'd1;
   localparam logic [1:0] MDU_DIV   = 2'd2;
   localparam logic [1:0] MDU_DIVU  = 2'd3;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   // MULT and DIV are the even encodings
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mul_div_step.sv
// rtl/mul_div_step.sv - one radix-2 iteration: shift-add multiply or restoring-divide trial subtract
module mul_div_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   always_comb begin
      // multiply: acc_lo holds the unconsumed multiplier bits, LSB first
      sum     = {1'b0, acc_hi} + {1'b0, operand & {WIDTH{acc_lo[0]}}};
      // divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, operand};
      fits    = (shifted >= {1'b0, operand});
      next_hi = '0;
      next_lo = '0;
      if (is_div) begin
         next_hi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         next_lo = {acc_lo[WIDTH-2:0], fits};
      end else begin
         next_hi = sum[WIDTH:1];
         next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;

   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [1:0]         state;
   logic [1:0]         op_q;
   logic [CW-1:0]      step;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   dividend;
   logic               sign_a;
   logic               sign_b;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   next_hi;
   logic [WIDTH-1:0]   next_lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;
   logic               neg_result;

   // the most negative value negates to itself, which is its correct unsigned magnitude
   assign mag_a = (op_is_signed(op) && opA[WIDTH-1]) ? -opA : opA;
   assign mag_b = (op_is_signed(op) && opB[WIDTH-1]) ? -opB : opB;

   assign busy = (state != IDLE);

   mul_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div  (op_is_div(op_q)),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand),
      .next_hi (next_hi),
      .next_lo (next_lo)
   );

   always_comb begin
      neg_result = op_is_signed(op_q) && (sign_a ^ sign_b);
      prod       = {acc_hi, acc_lo};
      res_hi     = '0;
      res_lo     = '0;
      if (op_is_div(op_q)) begin
         if (operand == '0) begin
            res_hi = dividend;
            res_lo = '1;
         end else begin
            res_lo = neg_result ? -acc_lo : acc_lo;
            res_hi = (op_is_signed(op_q) && sign_a) ? -acc_hi : acc_hi;
         end
      end else begin
         if (neg_result)
            prod = -prod;
         {res_hi, res_lo} = prod;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         step     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         operand  <= '0;
         dividend <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q     <= op;
                  step     <= '0;
                  acc_hi   <= '0;
                  acc_lo   <= op_is_div(op) ? mag_a : mag_b;
                  operand  <= op_is_div(op) ? mag_b : mag_a;
                  dividend <= opA;
                  sign_a   <= opA[WIDTH-1];
                  sign_b   <= opB[WIDTH-1];
                  state    <= CALC;
               end else begin
                  if (hiWrite)
                     hi <= wdata;
                  if (loWrite)
                     lo <= wdata;
               end
            end
            CALC: begin
               acc_hi <= next_hi;
               acc_lo <= next_lo;
               step   <= step + CW'(1);
               if (step == LAST_STEP)
                  state <= SIGN;
            end
            SIGN: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit at WIDTH=32
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic        hiWrite = 1'b0;
   logic        loWrite = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t tbl[8];

   mul_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .opA     (opA),
      .opB     (opB),
      .hiWrite (hiWrite),
      .loWrite (loWrite),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, p;
      logic [63:0] u;
      int ia, ib;
      ia = int'(a);
      ib = int'(b);
      sa = longint'(ia);
      sb = longint'(ib);
      h = '0;
      l = '0;
      case (o)
         MDU_MULT: begin
            p = sa * sb;
            {h, l} = p;
         end
         MDU_MULTU: begin
            u = {32'b0, a} * {32'b0, b};
            {h, l} = u;
         end
         MDU_DIV: begin
            if (b == 0) begin
               h = a;
               l = '1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               h = '0;
               l = a;
            end else begin
               l = 32'(ia / ib);
               h = 32'(ia % ib);
            end
         end
         default: begin
            if (b == 0) begin
               h = a;
               l = '1;
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // caller is at a negedge; returns at the negedge on which done is seen
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int lat;
      op = o;
      opA = a;
      opB = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " busy_after_start"}, 32'(busy), 32'd1);
      check({name, " done_low_after_start"}, 32'(done), 32'd0);
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      check({name, " latency"}, 32'(lat), 32'd33);
      if (lat != 0) begin
         check({name, " hi"}, hi, eh);
         check({name, " lo"}, lo, el);
         check({name, " busy_at_done"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] eh, el, a, b, hold_hi;
      logic [1:0]  o;
      int lat, seen;

      tbl[0] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[1] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      tbl[2] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[3] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[4] = '{MDU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
      tbl[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      tbl[6] = '{MDU_DIV,   32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF};
      tbl[7] = '{MDU_DIVU,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF};

      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      hiWrite = 1'b1;
      wdata = 32'hCAFE;
      @(negedge clk);
      hiWrite = 1'b0;
      check("mthi hi", hi, 32'hCAFE);
      check("mthi lo untouched", lo, 32'd0);

      hiWrite = 1'b1;
      loWrite = 1'b1;
      wdata = 32'h1111;
      @(negedge clk);
      hiWrite = 1'b0;
      loWrite = 1'b0;
      check("both strobes hi", hi, 32'h1111);
      check("both strobes lo", lo, 32'h1111);

      // table entries run back to back: each launch lands on the previous done cycle
      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el);

      loWrite = 1'b1;
      wdata = 32'h5555;
      @(negedge clk);
      loWrite = 1'b0;
      check("mtlo lo", lo, 32'h5555);
      hold_hi = hi;

      op = MDU_DIVU;
      opA = 32'd100;
      opB = 32'd7;
      start = 1'b1;
      loWrite = 1'b1;
      wdata = 32'hDEAD;
      @(negedge clk);
      start = 1'b0;
      loWrite = 1'b0;
      check("start wins over mtlo", lo, 32'h5555);
      hiWrite = 1'b1;
      wdata = 32'hBEEF;
      @(negedge clk);
      hiWrite = 1'b0;
      check("mthi while busy", hi, hold_hi);
      lat = 0;
      for (int k = 2; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      check("divu after drop latency", 32'(lat), 32'd33);
      check("divu after drop lo", lo, 32'd14);
      check("divu after drop hi", hi, 32'd2);

      op = MDU_MULTU;
      opA = 32'hFFFF_FFFF;
      opB = 32'hFFFF_FFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         if (k == 5) begin
            start = 1'b1;
            op = MDU_DIVU;
            opA = 32'd5;
            opB = 32'd0;
         end
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      check("ignored start latency", 32'(lat), 32'd33);
      check("ignored start hi", hi, 32'hFFFF_FFFE);
      check("ignored start lo", lo, 32'h0000_0001);
      @(negedge clk);
      check("done one cycle", 32'(done), 32'd0);
      check("no queued op", 32'(busy), 32'd0);

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         model(o, a, b, eh, el);
         run_op($sformatf("rnd%0d op%0d %h %h", i, o, a, b), o, a, b, eh, el);
      end

      op = MDU_MULTU;
      opA = 32'hFFFF_FFFF;
      opB = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done)
            seen++;
      end
      check("abort no done", 32'(seen), 32'd0);
      check("abort lo stays", lo, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
